// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM encoding, beat counter width, clog2 helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    // Beat counter is fixed at 8 bits so MAX_BURST can reach 256.
    localparam int BEAT_CNT_W = 8;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (w = 0; (1 << w) < value; w++) begin
        end
        return w;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin priority pick: first asserted request at or after rr_ptr, wrapping modulo NUM_REQ.
// Latency: combinational.
// Backpressure: none; pure function of req and rr_ptr.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int SRC_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SRC_W-1:0]   rr_ptr,
    output logic [SRC_W-1:0]   winner,
    output logic               any_valid
);

    int               cand;
    logic [SRC_W-1:0] cand_idx;
    logic             found;

    // Scan NUM_REQ positions starting at rr_ptr; the first hit wins.
    always_comb begin
        winner    = '0;
        any_valid = |req;
        found     = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = SRC_W'(cand);
            if (!found && req[cand_idx]) begin
                winner = cand_idx;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ valid/ready requesters.
// Latency: accepted beat appears on wr_en/wr_data 1 clk later; 1 idle arbitration clk between bursts.
// Backpressure: in_ready drops while full, or almost_full with a write in flight; grant and count hold.
// Build option FIFO_ARB_SRC_TAG_EN prepends the source index to wr_data (MSBs).
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 16,
    parameter  int MAX_BURST  = 8,
    localparam int SRC_W      = clog2(NUM_REQ),
`ifdef FIFO_ARB_SRC_TAG_EN
    localparam int FW         = DATA_WIDTH + SRC_W
`else
    localparam int FW         = DATA_WIDTH
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            in_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_REQ-1:0]            in_last,
    output logic [NUM_REQ-1:0]            in_ready,
    output logic                          wr_en,
    output logic [FW-1:0]                 wr_data,
    input  logic                          full,
    input  logic                          almost_full,
    output logic [SRC_W-1:0]              grant_id,
    output logic                          busy
);

    localparam logic [BEAT_CNT_W:0] MAX_BURST_W = (BEAT_CNT_W + 1)'(MAX_BURST);

    arb_state_e             state_q, state_d;
    logic [SRC_W-1:0]       grant_id_q, grant_id_d;
    logic [SRC_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [BEAT_CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic                   wr_en_q, wr_en_d;
    logic [FW-1:0]          wr_data_q, wr_data_d;

    logic [SRC_W-1:0]       winner;
    logic                   any_valid;
    logic                   space_ok;
    logic                   owner_valid;
    logic                   owner_last;
    logic [DATA_WIDTH-1:0]  owner_data;
    logic                   accept;
    logic [BEAT_CNT_W:0]    beat_cnt_inc;
    logic                   burst_exit;
    logic [SRC_W-1:0]       next_ptr;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .SRC_W   (SRC_W)
    ) u_rr_pick (
        .req       (in_valid),
        .rr_ptr    (rr_ptr_q),
        .winner    (winner),
        .any_valid (any_valid)
    );

    // A write registered last cycle has not landed yet, so almost_full must also stop us.
    assign space_ok = !full && !(almost_full && wr_en_q);

    // Select the current owner's handshake signals and payload.
    always_comb begin
        owner_valid = 1'b0;
        owner_last  = 1'b0;
        owner_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id_q == SRC_W'(i)) begin
                owner_valid = in_valid[i];
                owner_last  = in_last[i];
                owner_data  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign accept       = (state_q == ST_BURST) && owner_valid && space_ok;
    assign beat_cnt_inc = {1'b0, beat_cnt_q} + (BEAT_CNT_W + 1)'(1);
    // A FIFO stall is not an owner stall: only a dropped valid ends the burst early.
    assign burst_exit   = (state_q == ST_BURST) &&
                          (!owner_valid || (accept && (owner_last || beat_cnt_inc == MAX_BURST_W)));
    assign next_ptr     = (grant_id_q == SRC_W'(NUM_REQ - 1)) ? '0 : grant_id_q + SRC_W'(1);

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: arbitrate when anyone is valid, leave a burst on any exit condition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (any_valid)  state_d = ST_BURST;
            ST_BURST: if (burst_exit) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: only the owner sees ready, and only while the FIFO has room.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            in_ready[i] = (state_q == ST_BURST) && (grant_id_q == SRC_W'(i)) && space_ok;
        end
        busy = (state_q == ST_BURST);
    end

    // Datapath next values: grant latch, round-robin pointer, beat count and write register.
    always_comb begin
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        wr_en_d    = accept;
        wr_data_d  = wr_data_q;
        if (accept) begin
`ifdef FIFO_ARB_SRC_TAG_EN
            wr_data_d = {grant_id_q, owner_data};
`else
            wr_data_d = owner_data;
`endif
        end
        if (state_q == ST_IDLE) begin
            if (any_valid) begin
                grant_id_d = winner;
                beat_cnt_d = '0;
            end
        end else if (burst_exit) begin
            rr_ptr_d   = next_ptr;
            beat_cnt_d = '0;
        end else if (accept) begin
            beat_cnt_d = beat_cnt_inc[BEAT_CNT_W-1:0];
        end
    end

    // Datapath registers; reset drops any beat not yet written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
        end else begin
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_data  = wr_data_q;
    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter with a burst-level reference model and write scoreboard.
// Models a 32-deep FIFO (count only) with a random reader to create backpressure.
// Checks grant order, burst termination, in_ready, written data order and no write while full.
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DW      = 16;
    localparam int MAXB    = 8;
    localparam int DEPTH   = 32;
    localparam int SRC_W   = 2;
`ifdef FIFO_ARB_SRC_TAG_EN
    localparam int FW      = DW + SRC_W;
`else
    localparam int FW      = DW;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NUM_REQ-1:0]     in_valid;
    logic [NUM_REQ*DW-1:0]  in_data;
    logic [NUM_REQ-1:0]     in_last;
    logic [NUM_REQ-1:0]     in_ready;
    logic                   wr_en;
    logic [FW-1:0]          wr_data;
    logic                   full;
    logic                   almost_full;
    logic [SRC_W-1:0]       grant_id;
    logic                   busy;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MAXB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .full        (full),
        .almost_full (almost_full),
        .grant_id    (grant_id),
        .busy        (busy)
    );

    int errors = 0;
    int checks = 0;
    logic [FW-1:0] exp_q[$];

    // requester state: the beat currently on offer
    logic [DW-1:0] cur_data [NUM_REQ];
    logic          cur_last [NUM_REQ];
    int            fifo_cnt;
    logic [NUM_REQ-1:0] mask;
    int            pv, pl, prd;

    // burst-level reference model
    logic m_busy;
    int   m_owner, m_ptr, m_beats;

    typedef struct {
        logic [NUM_REQ-1:0] mask;
        int pv;
        int pl;
        int prd;
        int ncyc;
    } phase_t;

    phase_t ph [7] = '{
        '{4'b0001, 100, 12, 100, 200},
        '{4'b1111, 100,  0, 100, 300},
        '{4'b0010, 100,  0,   0,  80},
        '{4'b0010, 100,  0, 100, 100},
        '{4'b1111,  70, 20,  50, 600},
        '{4'b1100,  90, 10,  30, 400},
        '{4'b1111, 100,  0,  20, 300}
    };

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit pct(input int p);
        return int'($urandom_range(99, 0)) < p;
    endfunction

    function automatic int first_from(input int ptr, input logic [NUM_REQ-1:0] v);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
        end
        return 0;
    endfunction

    task automatic new_beat(input int i);
        cur_data[i] = DW'($urandom);
        cur_last[i] = pct(pl);
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < NUM_REQ; i++) begin
            in_valid[i]           = mask[i] && pct(pv);
            in_last[i]            = cur_last[i];
            in_data[i*DW +: DW]   = cur_data[i];
        end
    endtask

    // Write monitor: every FIFO write must match the oldest accepted beat.
    always @(negedge clk) begin
        if (!rst && wr_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got %0h expected no write at %0t", wr_data, $time);
            end else begin
                chk("wr_data", 32'(wr_data), 32'(exp_q.pop_front()));
            end
            chk("write_while_full", 32'(full), 32'(0));
        end
    end

    // One clock of stimulus: check at negedge, predict, then apply edge effects after posedge.
    task automatic cycle();
        logic [NUM_REQ-1:0] exp_rdy;
        logic [NUM_REQ-1:0] acc;
        logic               space;
        int                 nxt_cnt;
        @(negedge clk);
        chk("busy", 32'(busy), 32'(m_busy));
        if (m_busy) chk("grant_id", 32'(grant_id), 32'(m_owner));
        space   = !full && !(almost_full && wr_en);
        exp_rdy = '0;
        if (m_busy && space) exp_rdy[m_owner] = 1'b1;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        acc = in_valid & exp_rdy;
        if (acc != '0) begin
`ifdef FIFO_ARB_SRC_TAG_EN
            exp_q.push_back({SRC_W'(m_owner), cur_data[m_owner]});
`else
            exp_q.push_back(cur_data[m_owner]);
`endif
        end
        if (!m_busy) begin
            if (in_valid != '0) begin
                m_busy  = 1'b1;
                m_owner = first_from(m_ptr, in_valid);
                m_beats = 0;
            end
        end else if (!in_valid[m_owner] ||
                     (acc != '0 && (cur_last[m_owner] || m_beats + 1 == MAXB))) begin
            m_busy = 1'b0;
            m_ptr  = (m_owner + 1) % NUM_REQ;
        end else if (acc != '0) begin
            m_beats++;
        end
        nxt_cnt = fifo_cnt;
        if (pct(prd) && fifo_cnt > 0) nxt_cnt--;
        if (wr_en && nxt_cnt < DEPTH) nxt_cnt++;
        @(posedge clk);
        #1;
        fifo_cnt    = nxt_cnt;
        full        = (fifo_cnt >= DEPTH);
        almost_full = (fifo_cnt >= DEPTH - 1);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (acc[i]) new_beat(i);
        end
        drive_reqs();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"},     32'(busy),     32'(0));
        chk({tag, "_in_ready"}, 32'(in_ready), 32'(0));
        chk({tag, "_wr_en"},    32'(wr_en),    32'(0));
        chk({tag, "_wr_data"},  32'(wr_data),  32'(0));
        chk({tag, "_grant_id"}, 32'(grant_id), 32'(0));
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_busy  = 1'b0;
        m_owner = 0;
        m_ptr   = 0;
        m_beats = 0;
    endtask

    task automatic set_phase(input phase_t p);
        mask = p.mask;
        pv   = p.pv;
        pl   = p.pl;
        prd  = p.prd;
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = '0;
        in_last     = '0;
        in_data     = '0;
        full        = 1'b0;
        almost_full = 1'b0;
        fifo_cnt    = 0;
        mask        = '0;
        pv          = 0;
        pl          = 0;
        prd         = 100;
        for (int i = 0; i < NUM_REQ; i++) new_beat(i);
        model_reset();
        #1;
        check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int p = 0; p < 7; p++) begin
            set_phase(ph[p]);
            drive_reqs();
            for (int c = 0; c < ph[p].ncyc; c++) cycle();
        end

        // reset in the middle of a burst
        set_phase(ph[1]);
        begin
            int n;
            n = 0;
            while (!busy && n < 50) begin
                cycle();
                n++;
            end
        end
        chk("burst_started", 32'(busy), 32'(1));
        cycle();
        cycle();
        rst = 1'b1;
        #1;
        check_reset_outputs("midburst_reset");
        model_reset();
        in_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        drive_reqs();
        for (int c = 0; c < 400; c++) cycle();

        // drain: no more requests, all accepted beats must have been written
        mask = '0;
        drive_reqs();
        for (int c = 0; c < 10; c++) cycle();
        chk("drain_exp_empty", 32'(exp_q.size()), 32'(0));
        chk("drain_idle", 32'(busy), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
